// File: rtl/tx_feeder.sv
// Byte FIFO plus launch FSM that feeds a UART transmit serializer one byte per enable pulse.
// Optional sticky write-while-full flag is built when TX_FEEDER_OVERFLOW_EN is defined.
module tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              isDone,
  input  logic              ovf_clr,
  output logic              enable,
  output logic [7:0]        data_o_bus,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int CW = ADDR_W + 1;

  if (DEPTH < 2 || (1 << ADDR_W) != DEPTH) begin : g_bad_cfg
    $error("tx_feeder: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              enable_q, enable_d;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              wr_acc, pop;

  always_comb begin
    // A full FIFO drops the write even if a launch frees a slot this cycle.
    wr_acc   = wr_en & ~full_q;
    pop      = (state_q == IDLE) & ~empty_q;
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
    count_d  = count_q + CW'(wr_acc) - CW'(pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);

    state_d  = state_q;
    enable_d = enable_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (pop) begin
          data_d   = mem[rd_ptr_q];
          enable_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (isDone) begin
          enable_d = 1'b0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        enable_d = 1'b0;
        if (!isDone) state_d = IDLE;
      end
      default: begin
        enable_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

`ifdef TX_FEEDER_OVERFLOW_EN
    if (ovf_clr)              ovf_d = 1'b0;
    else if (wr_en && full_q) ovf_d = 1'b1;
    else                      ovf_d = ovf_q;
`else
    ovf_d = 1'b0;
`endif
  end

`ifndef TX_FEEDER_OVERFLOW_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      enable_q <= 1'b0;
      data_q   <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign enable     = enable_q;
  assign data_o_bus = data_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tx_feeder.sv
// Randomized + directed bench for tx_feeder: queue-based reference model feeds a scoreboard
// that a negedge monitor drains whenever the DUT launches a byte.
module tb_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0, rst = 1'b0, wr_en = 1'b0, ovf_clr = 1'b0;
  logic        man_done = 1'b0, ser_done = 1'b0, auto_ser = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        isDone, enable, full, empty, busy, overflow;
  logic [7:0]  data_o_bus;
  logic [AW:0] count;

  assign isDone = auto_ser ? ser_done : man_done;
  always #5 clk = ~clk;

  tx_feeder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .isDone(isDone),
    .ovf_clr(ovf_clr), .enable(enable), .data_o_bus(data_o_bus), .full(full),
    .empty(empty), .count(count), .busy(busy), .overflow(overflow)
  );

  int n_pass = 0, n_total = 0, n_launch = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: stored bytes as a queue, transmitter as launching/stopping/idle phases.
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_st = 0;          // 0 waiting for a byte, 1 byte out, 2 waiting for stop to end
  logic       m_en = 1'b0, m_ovf = 1'b0;
  bit         m_full;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_fifo.delete(); exp_q.delete();
      m_st = 0; m_en = 1'b0; m_ovf = 1'b0;
    end else begin
      m_full = (m_fifo.size() == DEPTH);
`ifdef TX_FEEDER_OVERFLOW_EN
      if (ovf_clr) m_ovf = 1'b0;
      else if (wr_en && m_full) m_ovf = 1'b1;
`endif
      case (m_st)
        0: if (m_fifo.size() > 0) begin
             exp_q.push_back(m_fifo.pop_front());
             m_en = 1'b1; m_st = 1;
           end
        1: if (isDone) begin m_en = 1'b0; m_st = 2; end
        default: if (!isDone) m_st = 0;
      endcase
      if (wr_en && !m_full) m_fifo.push_back(wr_data);
    end
  end

  // Monitor: status every cycle, launched byte against the scoreboard on each enable rise.
  logic       prev_en = 1'b0;
  logic [7:0] last_b  = 8'h00;
  always @(negedge clk) begin
    if (!rst) prev_en = 1'b0;
    else begin
      chk("enable", enable, m_en);
      chk("count", count, m_fifo.size());
      chk("full", full, m_fifo.size() == DEPTH);
      chk("empty", empty, m_fifo.size() == 0);
      chk("busy", busy, m_st != 0);
      chk("overflow", overflow, m_ovf);
      if (enable && !prev_en) begin
        n_launch++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL launch_unexpected: byte %0h launched, none expected at %0t", data_o_bus, $time);
        end else begin
          last_b = exp_q.pop_front();
          chk("launch_data", data_o_bus, last_b);
        end
      end else if (enable) chk("data_hold", data_o_bus, last_b);
      prev_en = enable;
    end
  end

  // Serializer model: random launch delay, random stop-phase length.
  int sc = 0, sp = 0;
  always @(posedge clk) begin
    #1;
    if (!auto_ser || !rst) begin
      ser_done = 1'b0; sc = $urandom_range(0, 3);
    end else if (ser_done) begin
      if (sp == 0) begin ser_done = 1'b0; sc = $urandom_range(0, 3); end
      else sp--;
    end else if (enable) begin
      if (sc == 0) begin ser_done = 1'b1; sp = $urandom_range(0, 2); end
      else sc--;
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    auto_ser = 1'b1;
    while ((m_fifo.size() != 0 || m_st != 0) && t < 3000) begin tick(); t++; end
    if (t >= 3000) begin
      n_total++;
      $display("FAIL drain_timeout: fifo %0d state %0d after %0d cycles", m_fifo.size(), m_st, t);
    end
    auto_ser = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, w;
    tick(); tick();
    chk("rst_enable", enable, 0); chk("rst_data", data_o_bus, 8'h00);
    chk("rst_count", count, 0);   chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);     chk("rst_busy", busy, 0); chk("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick();

    // Single byte
    wr(8'hA5);
    tick();
    chk("single_en", enable, 1); chk("single_data", data_o_bus, 8'hA5);
    repeat (4) tick();
    man_done = 1'b1; tick();
    chk("single_en_low", enable, 0);
    tick(); tick();
    man_done = 1'b0; tick();
    chk("single_busy_low", busy, 0);

    // Fill and overflow
    for (int d = 0; d <= 16; d++) wr(8'(d));
    wr(8'h11);
    chk("fill_count", count, 16); chk("fill_full", full, 1);
`ifdef TX_FEEDER_OVERFLOW_EN
    chk("fill_ovf", overflow, 1);
`else
    chk("fill_ovf", overflow, 0);
`endif
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    drain();

    // Simultaneous write and launch
    wr(8'hB0); wr(8'hB1); wr(8'hB2); wr(8'hB3);
    man_done = 1'b1; tick();
    man_done = 1'b0; tick();
    chk("simul_pre_count", count, 3);
    wr(8'hB4);
    chk("simul_count", count, 3); chk("simul_en", enable, 1); chk("simul_data", data_o_bus, 8'hB1);
    drain();

    // Order and wrap stream
    l0 = n_launch;
    auto_ser = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      w = 0;
      while (m_fifo.size() >= DEPTH && w < 200) begin tick(); w++; end
      wr(8'(i));
      repeat ($urandom_range(0, 4)) tick();
    end
    drain();
    chk("stream_launches", n_launch - l0, 40);
    chk("stream_empty", empty, 1);

    // Long stop
    wr(8'hC0); wr(8'hC1); tick();
    man_done = 1'b1;
    repeat (20) tick();
    chk("long_en", enable, 0); chk("long_busy", busy, 1); chk("long_count", count, 1);
    man_done = 1'b0; tick();
    chk("long_idle_en", enable, 0);
    tick();
    chk("long_relaunch", enable, 1); chk("long_data", data_o_bus, 8'hC1);
    drain();

    // Reset during SEND
    for (int d = 0; d < 6; d++) wr(8'(8'hD0 + d));
    chk("rsend_count", count, 5); chk("rsend_en", enable, 1);
    #1 rst = 1'b0;
    #1;
    chk("rsend_async_en", enable, 0); chk("rsend_count0", count, 0);
    chk("rsend_data0", data_o_bus, 8'h00); chk("rsend_empty", empty, 1);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("rsend_no_launch", enable, 0); chk("rsend_busy", busy, 0);
    wr(8'hE7); tick();
    chk("rsend_new_en", enable, 1); chk("rsend_new_data", data_o_bus, 8'hE7);
    drain();

    chk("final_scoreboard", exp_q.size(), 0);
    chk("final_empty", empty, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
